// File: rtl/lru_buf_ctrl.sv
// Four-entry buffer directory with LRU replacement and external fill sequencing.
// Optional feature macro: LRU_INV_EN adds a tag-invalidate port (inv_valid/inv_tag).
// order packs four 2-bit slots {o3,o2,o1,o0}; o0 is least recently used, o3 most recent.
module lru_buf_ctrl #(
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [1:0]       rsp_buf,
    output logic             fill_req,
    output logic [1:0]       fill_buf,
    output logic [TAG_W-1:0] fill_tag,
    input  logic             fill_done,
`ifdef LRU_INV_EN
    input  logic             inv_valid,
    input  logic [TAG_W-1:0] inv_tag,
`endif
    output logic             busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]       r_state;
    logic [TAG_W-1:0] r_tag;      // captured request tag, also drives fill_tag
    logic [3:0]       r_valid;
    logic [TAG_W-1:0] r_tags [4];
    logic [7:0]       r_order;
    logic [1:0]       r_buf;      // hit buffer or fill victim
    logic             r_hit;

    logic             w_hit;
    logic [1:0]       w_hit_idx;
    logic [1:0]       w_victim;
    logic [1:0]       w_touch_pos;
    logic [7:0]       w_touch_order;

    // Tag lookup of the captured request against all valid entries.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_valid[i] && (r_tags[i] == r_tag)) begin
                w_hit     = 1'b1;
                w_hit_idx = 2'(i);
            end
        end
    end

    // Victim: lowest-index invalid buffer, otherwise the LRU slot o0.
    always_comb begin
        w_victim = r_order[1:0];
        for (int i = 3; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_victim = 2'(i);
            end
        end
    end

    // LRU touch of r_buf: entries above its slot slide down one, r_buf lands in o3.
    always_comb begin
        w_touch_pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_order[2*i +: 2] == r_buf) begin
                w_touch_pos = 2'(i);
            end
        end
        w_touch_order = r_order;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) >= w_touch_pos) begin
                w_touch_order[2*i +: 2] = r_order[2*(i+1) +: 2];
            end
        end
        w_touch_order[7:6] = r_buf;
    end

`ifdef LRU_INV_EN
    logic       w_inv_hit;
    logic [1:0] w_inv_idx;
    logic [1:0] w_inv_pos;
    logic [7:0] w_inv_order;

    // Invalidate lookup; a matching buffer is demoted to o0 so it is reused first.
    always_comb begin
        w_inv_hit = 1'b0;
        w_inv_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_valid[i] && (r_tags[i] == inv_tag)) begin
                w_inv_hit = 1'b1;
                w_inv_idx = 2'(i);
            end
        end
        w_inv_pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_order[2*i +: 2] == w_inv_idx) begin
                w_inv_pos = 2'(i);
            end
        end
        w_inv_order = r_order;
        for (int i = 1; i < 4; i++) begin
            if (2'(i) <= w_inv_pos) begin
                w_inv_order[2*i +: 2] = r_order[2*(i-1) +: 2];
            end
        end
        w_inv_order[1:0] = w_inv_idx;
    end

    assign req_ready = (r_state == ST_IDLE) && !inv_valid;
`else
    assign req_ready = (r_state == ST_IDLE);
`endif

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_hit   = r_hit;
    assign rsp_buf   = r_buf;
    assign fill_req  = (r_state == ST_FILL);
    assign fill_buf  = r_buf;
    assign fill_tag  = r_tag;
    assign busy      = (r_state != ST_IDLE);

    // Controller FSM, directory and LRU order update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tag   <= '0;
            r_valid <= 4'b0000;
            r_order <= 8'b11_10_01_00;
            r_buf   <= 2'd0;
            r_hit   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_tags[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef LRU_INV_EN
                    if (inv_valid) begin
                        if (w_inv_hit) begin
                            r_valid[w_inv_idx] <= 1'b0;
                            r_order            <= w_inv_order;
                        end
                    end else if (req_valid) begin
                        r_tag   <= req_tag;
                        r_state <= ST_LOOKUP;
                    end
`else
                    if (req_valid) begin
                        r_tag   <= req_tag;
                        r_state <= ST_LOOKUP;
                    end
`endif
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_buf   <= w_hit_idx;
                        r_hit   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_buf   <= w_victim;
                        r_hit   <= 1'b0;
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_done) begin
                        r_tags[r_buf]  <= r_tag;
                        r_valid[r_buf] <= 1'b1;
                        r_state        <= ST_RESP;
                    end
                end
                default: begin
                    r_order <= w_touch_order;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lru_buf_ctrl.sv
// Self-checking bench for lru_buf_ctrl; expected responses are queued at request time
// and consumed by a monitor when rsp_valid strobes.
module tb_lru_buf_ctrl;

    localparam int unsigned TAG_W = 8;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic [TAG_W-1:0] req_tag;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [1:0]       rsp_buf;
    logic             fill_req;
    logic [1:0]       fill_buf;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_done;
    logic             busy;
`ifdef LRU_INV_EN
    logic             inv_valid;
    logic [TAG_W-1:0] inv_tag;
`endif

    typedef struct packed {
        logic       hit;
        logic [1:0] bufn;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    lru_buf_ctrl #(.TAG_W(TAG_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_hit   (rsp_hit),
        .rsp_buf   (rsp_buf),
        .fill_req  (fill_req),
        .fill_buf  (fill_buf),
        .fill_tag  (fill_tag),
        .fill_done (fill_done),
`ifdef LRU_INV_EN
        .inv_valid (inv_valid),
        .inv_tag   (inv_tag),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response scoreboard.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check_eq("rsp_hit", 32'(rsp_hit), 32'(e.hit));
                check_eq("rsp_buf", 32'(rsp_buf), 32'(e.bufn));
            end
        end
    end

    // Called at posedge+#1. Issues one request and plays the fill engine on a miss.
    task automatic do_req(input logic [7:0] tag, input logic exp_hit, input logic [1:0] exp_buf,
                          input int hold);
        int   n;
        logic ok;
        rsp_t e;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check_eq("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_tag   = tag;
        e.hit     = exp_hit;
        e.bufn    = exp_buf;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("lookup_busy", 32'(busy & ~req_ready & ~rsp_valid), 32'd1);
        @(posedge clk); #1;
        if (exp_hit) begin
            check_eq("hit_latency", 32'(rsp_valid), 32'd1);
            check_eq("hit_no_fill", 32'(fill_req), 32'd0);
        end else begin
            check_eq("fill_req", 32'(fill_req), 32'd1);
            check_eq("fill_buf", 32'(fill_buf), 32'(exp_buf));
            check_eq("fill_tag", 32'(fill_tag), 32'(tag));
            if (hold > 0) begin
                ok = 1'b1;
                req_valid = 1'b1;
                req_tag   = tag + 8'h55;
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk); #1;
                    ok &= fill_req && (fill_buf == exp_buf) && (fill_tag == tag) && !req_ready &&
                          busy && !rsp_valid;
                end
                req_valid = 1'b0;
                check_eq("fill_hold", 32'(ok), 32'd1);
            end
            fill_done = 1'b1;
            @(posedge clk); #1;
            fill_done = 1'b0;
            check_eq("miss_rsp", 32'(rsp_valid & ~fill_req), 32'd1);
        end
        @(posedge clk); #1;
        check_eq("back_idle", 32'(req_ready & ~rsp_valid & ~busy), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_tag   = '0;
        fill_done = 1'b0;
`ifdef LRU_INV_EN
        inv_valid = 1'b0;
        inv_tag   = '0;
`endif
        #12;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_outs", {24'd0, rsp_valid, rsp_hit, fill_req, busy, rsp_buf, fill_buf},
                 32'd0);
        check_eq("rst_fill_tag", 32'(fill_tag), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold misses fill the invalid buffers in index order.
        do_req(8'h10, 1'b0, 2'd0, 2);
        do_req(8'h11, 1'b0, 2'd1, 0);
        do_req(8'h12, 1'b0, 2'd2, 0);
        do_req(8'h13, 1'b0, 2'd3, 0);
        do_req(8'h11, 1'b1, 2'd1, 0);

        // fill_done while idle must not start anything.
        fill_done = 1'b1;
        @(posedge clk); #1;
        fill_done = 1'b0;
        check_eq("stray_fill_done", 32'(busy | rsp_valid), 32'd0);

        // Order now o0..o3 = 0,2,3,1.
        do_req(8'h20, 1'b0, 2'd0, 0);
        do_req(8'h10, 1'b0, 2'd2, 0);
        do_req(8'h12, 1'b0, 2'd3, 50);
        do_req(8'h20, 1'b1, 2'd0, 0);

        // Reset while filling: order now 1,2,3,0, so victim is buf 1.
        req_valid = 1'b1;
        req_tag   = 8'h22;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("pre_rst_fill", 32'(fill_req), 32'd1);
        check_eq("pre_rst_buf", 32'(fill_buf), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_fill_drop", 32'(fill_req), 32'd0);
        check_eq("async_idle", 32'(req_ready & ~busy), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(8'h40, 1'b0, 2'd0, 0);
        do_req(8'h40, 1'b1, 2'd0, 0);
        do_req(8'h20, 1'b0, 2'd1, 0);

`ifdef LRU_INV_EN
        do_req(8'h60, 1'b0, 2'd2, 0);
        do_req(8'h70, 1'b0, 2'd3, 0);
        // Order 0,1,2,3; invalidating buf 2 gives 2,0,1,3.
        inv_valid = 1'b1;
        inv_tag   = 8'h60;
        req_valid = 1'b1;
        req_tag   = 8'h40;
        #1;
        check_eq("inv_blocks_req", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        inv_valid = 1'b0;
        req_valid = 1'b0;
        check_eq("inv_stays_idle", 32'(busy), 32'd0);
        do_req(8'h80, 1'b0, 2'd2, 0);
        do_req(8'h60, 1'b0, 2'd0, 0);
        do_req(8'h20, 1'b1, 2'd1, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check_eq("rsp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
